// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM read path: default widths, the word
// stride used for sequential prefetch, FSM states and bus-idle levels.
// The prefetch states exist only when VRAM_READ_PREFETCH_EN is defined.
package vram_pkg;

    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_STATES = 2;

    // One VRAM word is two bytes of ISA address space.
    localparam int WORD_STRIDE = 2;

    // Wait counter covers the full 0..7 wait-state range.
    localparam int CNT_W = 3;

    // Levels of the active-low strobes when the bus is not ours.
    localparam logic CE_IDLE = 1'b1;
    localparam logic OE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BUS  = 3'd1,
        ST_ACCESS    = 3'd2,
`ifdef VRAM_READ_PREFETCH_EN
        ST_DONE      = 3'd3,
        ST_PF_WAIT   = 3'd4,
        ST_PF_ACCESS = 3'd5
`else
        ST_DONE      = 3'd3
`endif
    } state_t;

endpackage

// File: rtl/vram_access_seq.sv
// Timed VRAM read strobe sequencer. A start pulse asserts CE/OE/IO_EN on
// the next edge and holds them for WAIT_STATES+1 cycles; sample flags the
// last cycle, abort flags loss of the bus grant, which drops the strobes.
// Used for both demand and prefetch reads.
module vram_access_seq
    import vram_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic free,
    output logic ce_n,
    output logic oe_n,
    output logic io_en,
    output logic sample,
    output logic abort
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    logic             active;
    logic [CNT_W-1:0] count;

    assign sample = active & free & (count == '0);
    assign abort  = active & ~free;

    // Registered strobes: load on start, count down, release on completion or grant loss.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            count  <= '0;
            ce_n   <= CE_IDLE;
            oe_n   <= OE_IDLE;
            io_en  <= 1'b0;
        end else if (active) begin
            if (!free || (count == '0)) begin
                active <= 1'b0;
                ce_n   <= CE_IDLE;
                oe_n   <= OE_IDLE;
                io_en  <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end else if (start) begin
            active <= 1'b1;
            count  <= CNT_LOAD;
            ce_n   <= ~CE_IDLE;
            oe_n   <= ~OE_IDLE;
            io_en  <= 1'b1;
        end
    end

endmodule

// File: rtl/vram_read_prefetch.sv
// ISA-to-VRAM read path beside the write buffer on the shared VRAM bus.
// Accepts single-word reads, waits for the bus grant and an empty write
// buffer, runs a timed read and returns data with a one-cycle ack.
// Define VRAM_READ_PREFETCH_EN to add a one-word sequential prefetch.
module vram_read_prefetch
    import vram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clock,
    input  logic              RESET,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    input  logic              free,
    input  logic              wbuf_empty,
    input  logic              wr_snoop,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [DATA_W-1:0] vram_data_in,
    output logic              vram_ce_n,
    output logic              vram_oe_n,
    output logic              READBUF_IO_EN
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic              accept;
    logic              seq_start;
    logic              seq_sample;
    logic              seq_abort;

`ifdef VRAM_READ_PREFETCH_EN
    logic [ADDR_W-1:0] pf_addr;
    logic [DATA_W-1:0] pf_data;
    logic              pf_valid;
    logic              pend;
    logic              pf_discard;
    logic              hit_idle;
    logic              hit_pf;
    logic [ADDR_W-1:0] pend_addr;
    logic              in_pf_next;

    assign pend_addr  = pend ? cur_addr : req_addr;
    assign in_pf_next = (next_state == ST_PF_WAIT) || (next_state == ST_PF_ACCESS);
`else
    logic unused_snoop;
    assign unused_snoop = wr_snoop;
`endif

    vram_access_seq #(
        .WAIT_STATES (WAIT_STATES)
    ) u_seq (
        .clock  (clock),
        .reset  (RESET),
        .start  (seq_start),
        .free   (free),
        .ce_n   (vram_ce_n),
        .oe_n   (vram_oe_n),
        .io_en  (READBUF_IO_EN),
        .sample (seq_sample),
        .abort  (seq_abort)
    );

    assign rd_ack = (state == ST_DONE);

    // Next state and per-cycle controls; accesses start only with grant and empty write buffer.
    always_comb begin
        next_state = state;
        seq_start  = 1'b0;
        accept     = 1'b0;
`ifdef VRAM_READ_PREFETCH_EN
        hit_idle   = 1'b0;
        hit_pf     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    next_state = ST_WAIT_BUS;
`ifdef VRAM_READ_PREFETCH_EN
                    if (pf_valid && !wr_snoop && (req_addr == pf_addr)) begin
                        hit_idle   = 1'b1;
                        next_state = ST_DONE;
                    end
`endif
                end
            end
            ST_WAIT_BUS: begin
                if (free && wbuf_empty) begin
                    seq_start  = 1'b1;
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (seq_abort) begin
                    next_state = ST_WAIT_BUS;
                end else if (seq_sample) begin
                    next_state = ST_DONE;
                end
            end
`ifdef VRAM_READ_PREFETCH_EN
            ST_DONE: begin
                next_state = ST_PF_WAIT;
            end
            ST_PF_WAIT: begin
                if (pend) begin
                    next_state = ST_WAIT_BUS;
                end else if (req) begin
                    accept     = 1'b1;
                    next_state = ST_WAIT_BUS;
                end else if (free && wbuf_empty) begin
                    seq_start  = 1'b1;
                    next_state = ST_PF_ACCESS;
                end
            end
            ST_PF_ACCESS: begin
                if (req && !pend) begin
                    accept = 1'b1;
                end
                if (seq_abort) begin
                    next_state = ST_PF_WAIT;
                end else if (seq_sample) begin
                    if (!(pend || req)) begin
                        next_state = ST_IDLE;
                    end else if (!pf_discard && !wr_snoop && (pend_addr == pf_addr)) begin
                        hit_pf     = 1'b1;
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_WAIT_BUS;
                    end
                end
            end
`else
            ST_DONE: begin
                next_state = ST_IDLE;
            end
`endif
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Busy covers an ISA read from the cycle after acceptance through its ack.
    always_comb begin
        busy = 1'b0;
        case (state)
            ST_WAIT_BUS, ST_ACCESS, ST_DONE: busy = 1'b1;
`ifdef VRAM_READ_PREFETCH_EN
            ST_PF_WAIT, ST_PF_ACCESS:        busy = pend;
`endif
            default:                         busy = 1'b0;
        endcase
    end

    // State register, request address, VRAM address and returned data.
    always_ff @(posedge clock) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            vram_addr <= '0;
            rd_data   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cur_addr <= req_addr;
            end
`ifdef VRAM_READ_PREFETCH_EN
            if (seq_start) begin
                vram_addr <= (state == ST_PF_WAIT) ? pf_addr : cur_addr;
            end
            if ((state == ST_ACCESS) && seq_sample) begin
                rd_data <= vram_data_in;
            end else if (hit_idle) begin
                rd_data <= pf_data;
            end else if (hit_pf) begin
                rd_data <= vram_data_in;
            end
`else
            if (seq_start) begin
                vram_addr <= cur_addr;
            end
            if ((state == ST_ACCESS) && seq_sample) begin
                rd_data <= vram_data_in;
            end
`endif
        end
    end

`ifdef VRAM_READ_PREFETCH_EN
    // Prefetch buffer: next sequential address, stored word, validity, latched request and write invalidation.
    always_ff @(posedge clock) begin
        if (RESET) begin
            pf_addr    <= '0;
            pf_data    <= '0;
            pf_valid   <= 1'b0;
            pend       <= 1'b0;
            pf_discard <= 1'b0;
        end else begin
            if (state == ST_DONE) begin
                pf_addr <= cur_addr + ADDR_W'(WORD_STRIDE);
            end
            if ((state == ST_PF_ACCESS) && seq_sample) begin
                pf_data <= vram_data_in;
            end
            if ((state == ST_PF_ACCESS) && seq_sample && (next_state == ST_IDLE)) begin
                pf_valid <= !(pf_discard || wr_snoop);
            end else if ((state == ST_IDLE) && (next_state == ST_IDLE)) begin
                pf_valid <= pf_valid && !wr_snoop;
            end else begin
                pf_valid <= 1'b0;
            end
            if (in_pf_next) begin
                pend       <= pend | (accept && (state == ST_PF_ACCESS));
                pf_discard <= pf_discard | wr_snoop;
            end else begin
                pend       <= 1'b0;
                pf_discard <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vram_read_prefetch.sv
// Self-checking bench for vram_read_prefetch with a small VRAM model.
// Prefetch-dependent expectations follow VRAM_READ_PREFETCH_EN.
module tb_vram_read_prefetch;

    localparam int RUN_LEN = 24;

    logic        clock = 1'b0;
    logic        RESET;
    logic        req;
    logic [19:0] req_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        busy;
    logic        free;
    logic        wbuf_empty;
    logic        wr_snoop;
    logic [19:0] vram_addr;
    logic [15:0] vram_data_in;
    logic        vram_ce_n;
    logic        vram_oe_n;
    logic        io_en;
    logic [15:0] bias;

    vram_read_prefetch #(
        .ADDR_W      (20),
        .DATA_W      (16),
        .WAIT_STATES (2)
    ) dut (
        .clock         (clock),
        .RESET         (RESET),
        .req           (req),
        .req_addr      (req_addr),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .busy          (busy),
        .free          (free),
        .wbuf_empty    (wbuf_empty),
        .wr_snoop      (wr_snoop),
        .vram_addr     (vram_addr),
        .vram_data_in  (vram_data_in),
        .vram_ce_n     (vram_ce_n),
        .vram_oe_n     (vram_oe_n),
        .READBUF_IO_EN (io_en)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mem_word(input logic [19:0] a, input logic [15:0] b);
        if (a == 20'h12340) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A ^ b;
    endfunction

    always_comb vram_data_in = vram_oe_n ? 16'hDEAD : mem_word(vram_addr, bias);

    typedef struct {
        logic [19:0] addr;
        int          wbuf_delay;
        int          exp_ack;
        logic [15:0] exp_data;
        int          exp_ce_first;
    } vec_t;

    vec_t vecs [4];

    int          n_cmp;
    int          n_fail;
    int          ack_cycle;
    int          ack_count;
    int          busy_count;
    int          ce_first;
    int          ce_to_ack;
    int          strobe_bad;
    logic [15:0] ack_data;
    logic        ce_hist [0:RUN_LEN];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One read: req at edge 0, then RUN_LEN observed cycles with wbuf/free shaping.
    task automatic applyStimulus(input logic [19:0] addr, input int wbuf_delay,
                                 input int free_from, input int free_len);
        ack_cycle  = 0;
        ack_count  = 0;
        busy_count = 0;
        ce_first   = 0;
        ce_to_ack  = 0;
        strobe_bad = 0;
        ack_data   = '0;
        @(negedge clock);
        req        = 1'b1;
        req_addr   = addr;
        free       = 1'b1;
        wbuf_empty = 1'b1;
        @(negedge clock);
        req = 1'b0;
        for (int c = 1; c <= RUN_LEN; c++) begin
            wbuf_empty = (c > wbuf_delay);
            free       = !((c >= free_from) && (c < free_from + free_len));
            ce_hist[c] = vram_ce_n;
            if (rd_ack) begin
                ack_count++;
                if (ack_cycle == 0) begin
                    ack_cycle = c;
                    ack_data  = rd_data;
                end
            end
            if (busy) busy_count++;
            if (!vram_ce_n && (ce_first == 0)) ce_first = c;
            if ((vram_oe_n !== vram_ce_n) || (io_en !== !vram_ce_n)) strobe_bad++;
            @(negedge clock);
        end
        for (int c = 1; c <= RUN_LEN; c++) begin
            if ((c <= ack_cycle) && !ce_hist[c]) ce_to_ack++;
        end
        free       = 1'b1;
        wbuf_empty = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_ack"},    32'(rd_ack),    32'h0);
        checkOutput({tag, "_rd_data"},   32'(rd_data),   32'h0);
        checkOutput({tag, "_busy"},      32'(busy),      32'h0);
        checkOutput({tag, "_ce_n"},      32'(vram_ce_n), 32'h1);
        checkOutput({tag, "_oe_n"},      32'(vram_oe_n), 32'h1);
        checkOutput({tag, "_io_en"},     32'(io_en),     32'h0);
        checkOutput({tag, "_vram_addr"}, 32'(vram_addr), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;
        int lo;
        int exp_pf;
        n_cmp      = 0;
        n_fail     = 0;
        RESET      = 1'b1;
        req        = 1'b0;
        req_addr   = '0;
        free       = 1'b1;
        wbuf_empty = 1'b1;
        wr_snoop   = 1'b0;
        bias       = 16'h0000;

        vecs[0] = '{20'h12340,  0,  5, 16'hBEEF,  2};
        vecs[1] = '{20'h00100, 10, 15, 16'h5B5A, 12};
        vecs[2] = '{20'hABCDE,  3,  8, 16'hE684,  5};
        vecs[3] = '{20'h7FFF0,  1,  6, 16'hA5AA,  3};

`ifdef VRAM_READ_PREFETCH_EN
        exp_pf = 1;
`else
        exp_pf = 5;
`endif

        repeat (3) @(negedge clock);
        checkResetValues("por");
        RESET = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wbuf_delay, 0, 0);
            checkOutput($sformatf("v%0d_ack_cycle", i), 32'(ack_cycle),  32'(vecs[i].exp_ack));
            checkOutput($sformatf("v%0d_ack_count", i), 32'(ack_count),  32'd1);
            checkOutput($sformatf("v%0d_rd_data", i),   32'(ack_data),   32'(vecs[i].exp_data));
            checkOutput($sformatf("v%0d_busy_len", i),  32'(busy_count), 32'(vecs[i].exp_ack));
            checkOutput($sformatf("v%0d_ce_first", i),  32'(ce_first),   32'(vecs[i].exp_ce_first));
            checkOutput($sformatf("v%0d_ce_len", i),    32'(ce_to_ack),  32'd3);
            checkOutput($sformatf("v%0d_strobes", i),   32'(strobe_bad), 32'd0);
        end

        $display("[TB] free drop during access");
        applyStimulus(20'h00200, 0, 3, 3);
        hi = 0;
        lo = 0;
        for (int c = 4; c <= 6; c++) if (ce_hist[c]) hi++;
        for (int c = 7; c <= 10; c++) if (!ce_hist[c]) lo++;
        checkOutput("abort_ack_cycle", 32'(ack_cycle),  32'd10);
        checkOutput("abort_ack_count", 32'(ack_count),  32'd1);
        checkOutput("abort_rd_data",   32'(ack_data),   32'h585A);
        checkOutput("abort_busy_len",  32'(busy_count), 32'd10);
        checkOutput("abort_released",  32'(hi),         32'd3);
        checkOutput("abort_restart",   32'(lo),         32'd3);
        checkOutput("abort_ce_total",  32'(ce_to_ack),  32'd5);
        checkOutput("abort_strobes",   32'(strobe_bad), 32'd0);

        $display("[TB] reset during access");
        @(negedge clock);
        req      = 1'b1;
        req_addr = 20'h00300;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("mid_ce_active", 32'(vram_ce_n), 32'h0);
        RESET = 1'b1;
        @(negedge clock);
        checkResetValues("mid");
        RESET = 1'b0;
        applyStimulus(20'h00300, 0, 0, 0);
        checkOutput("post_rst_ack_cycle", 32'(ack_cycle), 32'd5);
        checkOutput("post_rst_rd_data",   32'(ack_data),  32'h595A);

        $display("[TB] sequential read across address wrap");
        applyStimulus(20'hFFFFE, 0, 0, 0);
        checkOutput("wrap0_ack_cycle", 32'(ack_cycle), 32'd5);
        checkOutput("wrap0_rd_data",   32'(ack_data),  32'hA5A4);
        applyStimulus(20'h00000, 0, 0, 0);
        checkOutput("wrap1_ack_cycle", 32'(ack_cycle),  32'(exp_pf));
        checkOutput("wrap1_ack_count", 32'(ack_count),  32'd1);
        checkOutput("wrap1_rd_data",   32'(ack_data),   32'h5A5A);
        checkOutput("wrap1_busy_len",  32'(busy_count), 32'(exp_pf));

        $display("[TB] write snoop invalidates prefetched word");
        @(negedge clock);
        wr_snoop = 1'b1;
        bias     = 16'h1111;
        @(negedge clock);
        wr_snoop = 1'b0;
        applyStimulus(20'h00002, 0, 0, 0);
        checkOutput("snoop_ack_cycle", 32'(ack_cycle),  32'd5);
        checkOutput("snoop_rd_data",   32'(ack_data),   32'h4B49);
        checkOutput("snoop_busy_len",  32'(busy_count), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
